// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Bit-serial adder. A start request in IDLE captures two WIDTH-bit operands
// and a carry-in. The block then makes one pass per clock through a single
// full adder, LSB first. The final sum and carry are presented in DONE
// together with a one-cycle done pulse. They stay on sum/cout until the next
// addition completes or reset is applied.
//
// Parameters
//   WIDTH          operand width in bits (1..32)
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   start          request to begin an addition (acted on only in IDLE)
//   a_in, b_in     operands, sampled together with start
//   cin            carry-in, sampled together with start
//   busy           high in RUN and DONE
//   sum_bit        serial sum bit of the current step, LSB first (0 outside RUN)
//   sum_bit_valid  high while sum_bit carries a result bit (RUN only)
//   done           one-cycle completion pulse (DONE state)
//   sum            parallel result, (a + b + cin) mod 2^WIDTH
//   cout           carry out of bit WIDTH-1
// -----------------------------------------------------------------------------
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             sum_bit,
  output logic             sum_bit_valid,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // The counter must be able to represent WIDTH itself, so it never wraps
  // during a run.
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // ---------------------------------------------------------------------------
  // Single-bit full adder helpers
  // ---------------------------------------------------------------------------
  function automatic logic fa_sum(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction

  function automatic logic fa_carry(input logic a, input logic b, input logic c);
    return (a & b) | (b & c) | (a & c);
  endfunction

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  state_t             state_r;
  state_t             state_next_s;

  logic [WIDTH-1:0]   a_sh_r;
  logic [WIDTH-1:0]   b_sh_r;
  logic [WIDTH-1:0]   sum_sh_r;
  logic               carry_r;
  logic [CNT_W-1:0]   cnt_r;

  logic [WIDTH-1:0]   sum_r;
  logic               cout_r;

  logic               fa_s_s;
  logic               fa_c_s;
  logic               last_bit_s;
  logic [WIDTH-1:0]   sum_sh_next_s;

  logic               busy_s;
  logic               done_s;
  logic               sum_bit_s;
  logic               sum_bit_valid_s;

  // ---------------------------------------------------------------------------
  // Datapath combinational terms
  // ---------------------------------------------------------------------------
  assign fa_s_s = fa_sum(a_sh_r[0], b_sh_r[0], carry_r);
  assign fa_c_s = fa_carry(a_sh_r[0], b_sh_r[0], carry_r);

  // The step that brings the counter up to WIDTH is the last one in RUN.
  assign last_bit_s = (cnt_r == CNT_W'(WIDTH - 1));

  // The new sum bit enters at the MSB end. After WIDTH steps the first bit
  // computed has moved down to bit 0. The concatenate-and-truncate form also
  // works for WIDTH = 1, where a [WIDTH-1:1] slice would be empty.
  assign sum_sh_next_s = WIDTH'({fa_s_s, sum_sh_r} >> 1);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // State register with asynchronous reset to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // Next-state decode. start is looked at only in IDLE.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (last_bit_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = RUN;
        end
      end
      DONE: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output decode
  // ---------------------------------------------------------------------------
  // Output decode. The outputs come from the state register and datapath
  // flops only, never directly from the primary inputs.
  always_comb begin
    busy_s          = 1'b0;
    done_s          = 1'b0;
    sum_bit_s       = 1'b0;
    sum_bit_valid_s = 1'b0;
    case (state_r)
      IDLE: begin
        busy_s = 1'b0;
      end
      RUN: begin
        busy_s          = 1'b1;
        sum_bit_s       = fa_s_s;
        sum_bit_valid_s = 1'b1;
      end
      DONE: begin
        busy_s = 1'b1;
        done_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: operand shifters, carry flop, sum shifter, bit counter
  // ---------------------------------------------------------------------------
  // Operand capture on an accepted start, then one full-adder step per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_r   <= '0;
      b_sh_r   <= '0;
      sum_sh_r <= '0;
      carry_r  <= 1'b0;
      cnt_r    <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            a_sh_r  <= a_in;
            b_sh_r  <= b_in;
            carry_r <= cin;
            cnt_r   <= '0;
          end else begin
            cnt_r   <= cnt_r;
          end
        end
        RUN: begin
          sum_sh_r <= sum_sh_next_s;
          carry_r  <= fa_c_s;
          a_sh_r   <= a_sh_r >> 1;
          b_sh_r   <= b_sh_r >> 1;
          cnt_r    <= cnt_r + CNT_W'(1);
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Result registers
  // ---------------------------------------------------------------------------
  // The parallel result is captured on the final RUN step, so it becomes
  // visible in DONE. It then holds through IDLE and the next run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_r  <= '0;
      cout_r <= 1'b0;
    end else begin
      if ((state_r == RUN) && last_bit_s) begin
        sum_r  <= sum_sh_next_s;
        cout_r <= fa_c_s;
      end else begin
        sum_r  <= sum_r;
        cout_r <= cout_r;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Port assignments
  // ---------------------------------------------------------------------------
  assign busy          = busy_s;
  assign done          = done_s;
  assign sum_bit       = sum_bit_s;
  assign sum_bit_valid = sum_bit_valid_s;
  assign sum           = sum_r;
  assign cout          = cout_r;

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//
// Self-checking bench for serial_adder. It uses one WIDTH=8 instance and one
// WIDTH=1 instance. Expected {cout,sum} values are pushed to a scoreboard
// queue when an addition is requested, and popped when done is observed.
// -----------------------------------------------------------------------------
module tb_serial_adder;

  logic       clk;
  logic       rst_n;

  logic       start8;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       cin8;
  logic       busy8;
  logic       sb8;
  logic       sbv8;
  logic       done8;
  logic [7:0] sum8;
  logic       cout8;

  logic       start1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       cin1;
  logic       busy1;
  logic       sb1;
  logic       sbv1;
  logic       done1;
  logic [0:0] sum1;
  logic       cout1;

  int n_checks;
  int n_miscompares;

  logic [8:0] exp8_q[$];
  logic [1:0] exp1_q[$];

  serial_adder #(.WIDTH(8)) dut8 (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start8),
    .a_in          (a8),
    .b_in          (b8),
    .cin           (cin8),
    .busy          (busy8),
    .sum_bit       (sb8),
    .sum_bit_valid (sbv8),
    .done          (done8),
    .sum           (sum8),
    .cout          (cout8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start1),
    .a_in          (a1),
    .b_in          (b1),
    .cin           (cin1),
    .busy          (busy1),
    .sum_bit       (sb1),
    .sum_bit_valid (sbv1),
    .done          (done1),
    .sum           (sum1),
    .cout          (cout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  // One WIDTH=8 addition. If glitch is set, a second start request with
  // different operands is issued in RUN cycle 3. That request must be ignored.
  task automatic do_add8(input logic [7:0] a, input logic [7:0] b, input logic c, input bit glitch);
    logic [8:0] full;
    logic [8:0] exp_v;
    int cyc;
    bit seen;
    full = 9'(a) + 9'(b) + 9'(c);
    exp8_q.push_back(full);
    @(negedge clk);
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (glitch && cyc == 3) begin
        start8 = 1'b1; a8 = ~a; b8 = 8'h77; cin8 = ~c;
      end else begin
        start8 = 1'b0;
      end
      if (done8) begin
        seen = 1'b1;
      end else begin
        check_value("run_busy", 32'(busy8), 32'd1);
        check_value("run_sbv", 32'(sbv8), 32'd1);
        if (cyc <= 8) check_value("sum_bit", 32'(sb8), 32'(full[cyc-1]));
      end
    end
    start8 = 1'b0;
    check_value("done_latency", seen ? 32'(cyc) : 32'd0, 32'd9);
    exp_v = exp8_q.pop_front();
    if (seen) begin
      check_value("sum8", 32'(sum8), 32'(exp_v[7:0]));
      check_value("cout8", 32'(cout8), 32'(exp_v[8]));
      check_value("done_busy", 32'(busy8), 32'd1);
      check_value("done_sbv", 32'(sbv8), 32'd0);
      check_value("done_sb", 32'(sb8), 32'd0);
    end
    @(negedge clk);
    check_value("idle_done", 32'(done8), 32'd0);
    check_value("idle_busy", 32'(busy8), 32'd0);
    check_value("idle_sbv", 32'(sbv8), 32'd0);
    check_value("hold_sum8", 32'(sum8), 32'(full[7:0]));
    check_value("hold_cout8", 32'(cout8), 32'(full[8]));
  endtask

  // One WIDTH=1 addition. exp_cs is the truth-table entry {cout,sum}.
  task automatic do_add1(input logic a, input logic b, input logic c, input logic [1:0] exp_cs);
    logic [1:0] exp_v;
    int cyc;
    bit seen;
    exp1_q.push_back(exp_cs);
    @(negedge clk);
    a1 = a; b1 = b; cin1 = c; start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (done1) begin
        seen = 1'b1;
      end else begin
        check_value("w1_busy", 32'(busy1), 32'd1);
        check_value("w1_sbv", 32'(sbv1), 32'd1);
        check_value("w1_sum_bit", 32'(sb1), 32'(exp_cs[0]));
      end
    end
    check_value("w1_latency", seen ? 32'(cyc) : 32'd0, 32'd2);
    exp_v = exp1_q.pop_front();
    if (seen) begin
      check_value("w1_cout_sum", 32'({cout1, sum1}), 32'(exp_v));
    end
    @(negedge clk);
    check_value("w1_idle_busy", 32'(busy1), 32'd0);
    check_value("w1_idle_done", 32'(done1), 32'd0);
  endtask

  initial begin
    logic [1:0] tt[8];
    logic [2:0] combo;
    bit saw_done;
    n_checks = 0;
    n_miscompares = 0;
    tt[0] = 2'b00; tt[1] = 2'b01; tt[2] = 2'b01; tt[3] = 2'b10;
    tt[4] = 2'b01; tt[5] = 2'b10; tt[6] = 2'b10; tt[7] = 2'b11;

    rst_n = 1'b0;
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    repeat (2) @(negedge clk);
    check_value("rst_busy", 32'(busy8), 32'd0);
    check_value("rst_done", 32'(done8), 32'd0);
    check_value("rst_sbv", 32'(sbv8), 32'd0);
    check_value("rst_sb", 32'(sb8), 32'd0);
    check_value("rst_sum", 32'(sum8), 32'd0);
    check_value("rst_cout", 32'(cout8), 32'd0);
    check_value("rst_w1", 32'({busy1, done1, sbv1, sb1, sum1, cout1}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_add8(8'h00, 8'h00, 1'b0, 1'b0);
    do_add8(8'hFF, 8'h01, 1'b0, 1'b0);
    do_add8(8'hA5, 8'h5A, 1'b1, 1'b0);
    do_add8(8'h3C, 8'h0F, 1'b0, 1'b0);
    do_add8(8'h12, 8'h34, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      do_add8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
    end
    do_add8(8'h3C, 8'h0F, 1'b0, 1'b0);

    // Abort a run with reset during RUN cycle 4.
    @(negedge clk);
    a8 = 8'h81; b8 = 8'h7E; cin8 = 1'b1; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (4) @(negedge clk);
    check_value("pre_abort_busy", 32'(busy8), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_value("abort_busy", 32'(busy8), 32'd0);
    check_value("abort_done", 32'(done8), 32'd0);
    check_value("abort_sbv", 32'(sbv8), 32'd0);
    check_value("abort_sb", 32'(sb8), 32'd0);
    check_value("abort_sum", 32'(sum8), 32'd0);
    check_value("abort_cout", 32'(cout8), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8 || busy8) saw_done = 1'b1;
    end
    check_value("no_done_after_abort", 32'(saw_done), 32'd0);
    do_add8(8'hC8, 8'h64, 1'b1, 1'b0);

    for (int i = 0; i < 8; i++) begin
      combo = 3'(i);
      do_add1(combo[2], combo[1], combo[0], tt[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miscompares);
    $finish;
  end

endmodule
